// File: rtl/sobel_window.sv
// rtl/sobel_window.sv - 3x3 raster window generator with two line buffers for Sobel-style filters.
// Optional SOBEL_WINDOW_SOF_EN adds in_sof to force the current pixel to position (0,0).
module sobel_window #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
`ifdef SOBEL_WINDOW_SOF_EN
   input  logic       in_sof,
`endif
   output logic [7:0] pix_0,
   output logic [7:0] pix_1,
   output logic [7:0] pix_2,
   output logic [7:0] pix_3,
   output logic [7:0] pix_4,
   output logic [7:0] pix_5,
   output logic [7:0] pix_6,
   output logic [7:0] pix_7,
   output logic [7:0] pix_8,
   output logic       out_valid,
   output logic       frame_end
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [7:0]    r_lb1 [IMG_WIDTH];
   logic [7:0]    r_lb2 [IMG_WIDTH];
   logic [7:0]    r_win [9];
   logic          r_out_valid;
   logic          r_frame_end;

   logic [CW-1:0] w_col;
   logic [RW-1:0] w_row;
   logic          w_last_col;
   logic          w_last_row;
   logic [7:0]    w_up1;
   logic [7:0]    w_up2;

   // A start-of-frame strobe relocates the current pixel to (0,0), so the aborted
   // frame can never complete a window: rows 0/1 of the new frame refill the buffers.
`ifdef SOBEL_WINDOW_SOF_EN
   assign w_col = in_sof ? '0 : r_col;
   assign w_row = in_sof ? '0 : r_row;
`else
   assign w_col = r_col;
   assign w_row = r_row;
`endif

   assign w_last_col = (w_col == CW'(IMG_WIDTH - 1));
   assign w_last_row = (w_row == RW'(IMG_HEIGHT - 1));
   assign w_up1      = r_lb1[w_col];
   assign w_up2      = r_lb2[w_col];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (in_valid) begin
         if (w_last_col) begin
            r_col <= '0;
            r_row <= w_last_row ? '0 : w_row + 1'b1;
         end else begin
            r_col <= w_col + 1'b1;
            r_row <= w_row;
         end
      end
   end

   // Line buffers carry no reset; output qualification on row>=2 hides stale contents.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         r_lb2[w_col] <= w_up1;
         r_lb1[w_col] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 9; i++) r_win[i] <= '0;
         r_out_valid <= 1'b0;
         r_frame_end <= 1'b0;
      end else begin
         r_out_valid <= in_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));
         r_frame_end <= in_valid && w_last_row && w_last_col;
         if (in_valid) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_up2;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_up1;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= in_data;
         end
      end
   end

   assign pix_0     = r_win[0];
   assign pix_1     = r_win[1];
   assign pix_2     = r_win[2];
   assign pix_3     = r_win[3];
   assign pix_4     = r_win[4];
   assign pix_5     = r_win[5];
   assign pix_6     = r_win[6];
   assign pix_7     = r_win[7];
   assign pix_8     = r_win[8];
   assign out_valid = r_out_valid;
   assign frame_end = r_frame_end;

endmodule
